ghost_move_scheduler: RTL and testbench

//  Time-multiplexes one shared ghost_control instance (with its valid_move_detector) across NUM_GHOSTS ghosts.
//  On each frame_tick it walks the enabled ghosts in ascending index order.
//  For each ghost it drives that ghost's position and previous direction into ghost_control and waits the pipeline latency.
//  It then captures move_direction into that ghost's direction register.

---
 rtl/ghost_move_scheduler.sv | 172 +++++++++++++++++
 tb/tb_ghost_move_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_move_scheduler.sv
// ghost_move_scheduler
//   Time-multiplexes a single ghost_control datapath across NUM_GHOSTS ghosts.
//   Each frame_tick starts a round that walks the enabled ghosts in ascending
//   index order. For each ghost it presents position and previous direction on
//   ctrl_*, waits CTRL_LAT cycles, then captures ctrl_move_dir into that
//   ghost's direction register.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   frame_tick      1-cycle pulse that starts a round (ignored while busy)
//   ghost_en        per-ghost enable, latched at round start
//   ghost_pos_x/y   flat ghost positions, sampled when each ghost is loaded
//   ctrl_ghost_x/y  registered position driven into ghost_control
//   ctrl_prev_dir   registered previous direction driven into ghost_control
//   ctrl_move_dir   move direction returned by ghost_control
//   ghost_dir       flat per-ghost one-hot direction (R=0001 U=0010 D=0100 L=1000)
//   cur_ghost       index of the ghost being served (holds in IDLE)
//   busy            high from round start until round_done
//   round_done      1-cycle pulse at end of round
//   overrun         sticky flag: frame_tick arrived while busy
module ghost_move_scheduler #(
    parameter int          NUM_GHOSTS = 4,
    parameter int          CTRL_LAT   = 2,
    parameter logic [3:0]  RESET_DIR  = 4'b1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic [NUM_GHOSTS-1:0]     ghost_en,
    input  logic [11*NUM_GHOSTS-1:0]  ghost_pos_x,
    input  logic [10*NUM_GHOSTS-1:0]  ghost_pos_y,
    output logic [10:0]               ctrl_ghost_x,
    output logic [9:0]                ctrl_ghost_y,
    output logic [3:0]                ctrl_prev_dir,
    input  logic [3:0]                ctrl_move_dir,
    output logic [4*NUM_GHOSTS-1:0]   ghost_dir,
    output logic [2:0]                cur_ghost,
    output logic                      busy,
    output logic                      round_done,
    output logic                      overrun
);

    localparam int IW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int WW = $clog2(CTRL_LAT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_DONE} state_e;

    state_e                 state_q, state_d;
    logic [NUM_GHOSTS-1:0]  mask_q, mask_d;
    logic [IW-1:0]          cur_q, cur_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [10:0]            ctrl_x_q, ctrl_x_d;
    logic [9:0]             ctrl_y_q, ctrl_y_d;
    logic [3:0]             ctrl_pd_q, ctrl_pd_d;
    logic [3:0]             dir_q [NUM_GHOSTS];
    logic [3:0]             dir_d [NUM_GHOSTS];
    logic                   overrun_q, overrun_d;

    logic                   load_en;
    logic [IW-1:0]          load_idx;
    logic [NUM_GHOSTS-1:0]  remain;

    // Index of the lowest set bit; callers only use it with a nonzero mask.
    function automatic logic [IW-1:0] lowest(input logic [NUM_GHOSTS-1:0] m);
        lowest = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (m[i]) lowest = IW'(i);
        end
    endfunction

    // NOTE: every variable written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cur_d     = cur_q;
        wait_d    = wait_q;
        ctrl_x_d  = ctrl_x_q;
        ctrl_y_d  = ctrl_y_q;
        ctrl_pd_d = ctrl_pd_q;
        dir_d     = dir_q;
        overrun_d = overrun_q | (frame_tick & (state_q != ST_IDLE));
        load_en   = 1'b0;
        load_idx  = '0;
        remain    = mask_q;
        remain[cur_q] = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    mask_d = ghost_en;
                    if (ghost_en != '0) begin
                        state_d  = ST_SERVE;
                        load_en  = 1'b1;
                        load_idx = lowest(ghost_en);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SERVE: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WW'(1);
                end else begin
                    // A zero result means "no legal move": keep the old heading.
                    if (ctrl_move_dir != 4'b0000) dir_d[cur_q] = ctrl_move_dir;
                    mask_d = remain;
                    if (remain != '0) begin
                        load_en  = 1'b1;
                        load_idx = lowest(remain);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Present the next ghost to ghost_control on the same edge that
        // starts the round or finishes the previous ghost.
        if (load_en) begin
            cur_d     = load_idx;
            ctrl_x_d  = ghost_pos_x[11*load_idx +: 11];
            ctrl_y_d  = ghost_pos_y[10*load_idx +: 10];
            ctrl_pd_d = dir_q[load_idx];
            wait_d    = WW'(CTRL_LAT);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            cur_q     <= '0;
            wait_q    <= '0;
            ctrl_x_q  <= '0;
            ctrl_y_q  <= '0;
            ctrl_pd_q <= '0;
            overrun_q <= 1'b0;
            // NOTE: the direction array is reset explicitly because ghosts
            // must start heading RESET_DIR; it is a small register bank, not RAM.
            for (int i = 0; i < NUM_GHOSTS; i++) dir_q[i] <= RESET_DIR;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            cur_q     <= cur_d;
            wait_q    <= wait_d;
            ctrl_x_q  <= ctrl_x_d;
            ctrl_y_q  <= ctrl_y_d;
            ctrl_pd_q <= ctrl_pd_d;
            overrun_q <= overrun_d;
            dir_q     <= dir_d;
        end
    end

    always_comb begin
        ghost_dir = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) ghost_dir[4*i +: 4] = dir_q[i];
    end

    assign ctrl_ghost_x  = ctrl_x_q;
    assign ctrl_ghost_y  = ctrl_y_q;
    assign ctrl_prev_dir = ctrl_pd_q;
    assign cur_ghost     = 3'(cur_q);
    assign busy          = (state_q != ST_IDLE);
    assign round_done    = (state_q == ST_DONE);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Testbench for ghost_move_scheduler: directed rounds followed by random
// rounds. A reference model computes each round's serve order and final
// directions into scoreboard queues; a monitor checks them as the DUT runs.
module tb_ghost_move_scheduler;

    localparam int NG = 4;
    localparam int L  = 2;

    logic              clk;
    logic              rst_n;
    logic              frame_tick;
    logic [NG-1:0]     ghost_en;
    logic [11*NG-1:0]  ghost_pos_x;
    logic [10*NG-1:0]  ghost_pos_y;
    logic [10:0]       ctrl_ghost_x;
    logic [9:0]        ctrl_ghost_y;
    logic [3:0]        ctrl_prev_dir;
    logic [3:0]        ctrl_move_dir;
    logic [4*NG-1:0]   ghost_dir;
    logic [2:0]        cur_ghost;
    logic              busy;
    logic              round_done;
    logic              overrun;

    ghost_move_scheduler #(.NUM_GHOSTS(NG), .CTRL_LAT(L), .RESET_DIR(4'b1000)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .ghost_en(ghost_en),
        .ghost_pos_x(ghost_pos_x), .ghost_pos_y(ghost_pos_y),
        .ctrl_ghost_x(ctrl_ghost_x), .ctrl_ghost_y(ctrl_ghost_y),
        .ctrl_prev_dir(ctrl_prev_dir), .ctrl_move_dir(ctrl_move_dir),
        .ghost_dir(ghost_dir), .cur_ghost(cur_ghost), .busy(busy),
        .round_done(round_done), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int g; logic [10:0] x; logic [9:0] y; logic [3:0] pd; } serve_t;
    typedef struct { logic [4*NG-1:0] dirs; int len; } round_t;

    serve_t      serve_q[$];
    round_t      round_q[$];
    logic [3:0]  mdir [NG];
    logic [3:0]  resp [8];
    logic [10:0] px [NG];
    logic [9:0]  py [NG];
    int          checks = 0;
    int          failures = 0;
    int          done_seen = 0;
    int          done_target = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*NG-1:0] pack_dirs();
        logic [4*NG-1:0] v;
        for (int i = 0; i < NG; i++) v[4*i +: 4] = mdir[i];
        return v;
    endfunction

    // ghost_control stand-in: its answer becomes valid L cycles after the
    // inputs it sees change; before that it returns the bitwise complement,
    // so an early capture stores a wrong value.
    initial begin
        logic [27:0] last_sig;
        logic        busy_last;
        int          age;
        ctrl_move_dir = 4'b0000;
        last_sig = '0;
        busy_last = 1'b0;
        age = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!busy_last || {cur_ghost, ctrl_ghost_x, ctrl_ghost_y, ctrl_prev_dir} != last_sig)
                age = 0;
            else
                age++;
            last_sig  = {cur_ghost, ctrl_ghost_x, ctrl_ghost_y, ctrl_prev_dir};
            busy_last = busy;
            ctrl_move_dir = (age >= L) ? resp[cur_ghost] : ~resp[cur_ghost];
        end
    end

    // Monitor: cycle offsets are counted from the first busy cycle. Ghost j is
    // presented at offset j*(L+1); round_done appears at offset k*(L+1).
    initial begin
        int     cyc;
        logic   busy_prev;
        serve_t s;
        round_t r;
        cyc = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0;
                busy_prev = 1'b0;
            end else begin
                if (busy && !busy_prev) cyc = 0;
                else if (busy) cyc++;
                busy_prev = busy;
                if (busy && !round_done && (cyc % (L + 1)) == 0) begin
                    if (serve_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL serve_unexpected: ghost %0d presented with no serve expected", cur_ghost);
                    end else begin
                        s = serve_q.pop_front();
                        check("serve_cur_ghost", 64'(cur_ghost), 64'(s.g));
                        check("serve_ctrl_x", 64'(ctrl_ghost_x), 64'(s.x));
                        check("serve_ctrl_y", 64'(ctrl_ghost_y), 64'(s.y));
                        check("serve_prev_dir", 64'(ctrl_prev_dir), 64'(s.pd));
                    end
                end
                if (round_done) begin
                    done_seen++;
                    if (round_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL round_unexpected: round_done with no round pending");
                    end else begin
                        r = round_q.pop_front();
                        check("round_dirs", 64'(ghost_dir), 64'(r.dirs));
                        check("round_length", 64'(cyc), 64'(r.len));
                        check("round_serves_left", 64'(serve_q.size()), 64'(0));
                    end
                end
            end
        end
    end

    // Starts a round at the next negedge; the model computes the expected serve
    // sequence and final directions from the enable mask and response table.
    task automatic start_round(input logic [NG-1:0] en);
        serve_t s;
        round_t r;
        int     k;
        @(negedge clk);
        for (int i = 0; i < NG; i++) begin
            px[i] = 11'($urandom_range(0, 2047));
            py[i] = 10'($urandom_range(0, 1023));
            ghost_pos_x[11*i +: 11] = px[i];
            ghost_pos_y[10*i +: 10] = py[i];
        end
        k = 0;
        for (int i = 0; i < NG; i++) begin
            if (en[i]) begin
                s.g = i; s.x = px[i]; s.y = py[i]; s.pd = mdir[i];
                serve_q.push_back(s);
                if (resp[i] != 4'b0000) mdir[i] = resp[i];
                k++;
            end
        end
        r.dirs = pack_dirs();
        r.len  = k * (L + 1);
        round_q.push_back(r);
        done_target = done_seen + 1;
        ghost_en   = en;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        ghost_en   = NG'($urandom);  // must be ignored until the next round
    endtask

    task automatic wait_done();
        for (int c = 0; c < NG * (L + 1) + 10; c++) begin
            if (done_seen >= done_target) break;
            @(negedge clk);
            #1;
        end
        check("round_finished_in_time", 64'(done_seen >= done_target), 64'(1));
    endtask

    task automatic rand_resp();
        for (int i = 0; i < 8; i++)
            resp[i] = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dirs"}, 64'(ghost_dir), 64'({NG{4'b1000}}));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_round_done"}, 64'(round_done), 64'(0));
        check({tag, "_overrun"}, 64'(overrun), 64'(0));
        check({tag, "_cur_ghost"}, 64'(cur_ghost), 64'(0));
        check({tag, "_ctrl"}, 64'({ctrl_ghost_x, ctrl_ghost_y, ctrl_prev_dir}), 64'(0));
    endtask

    initial begin
        logic [3:0] pre_dir0;
        logic [NG-1:0] en;
        rst_n = 1'b0;
        frame_tick = 1'b0;
        ghost_en = '0;
        ghost_pos_x = '0;
        ghost_pos_y = '0;
        for (int i = 0; i < NG; i++) mdir[i] = 4'b1000;
        for (int i = 0; i < 8; i++) resp[i] = 4'b0000;

        // T1: reset values, then an empty round
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        start_round('0);
        wait_done();

        // T2: full round with one-hot answers per ghost
        resp[0] = 4'b0001; resp[1] = 4'b0010; resp[2] = 4'b0100; resp[3] = 4'b1000;
        start_round(4'b1111);
        wait_done();
        check("t2_final_dirs", 64'(ghost_dir), 64'({4'b1000, 4'b0100, 4'b0010, 4'b0001}));

        // T3: only ghosts 1 and 3 enabled
        resp[1] = 4'b0100; resp[3] = 4'b0001;
        start_round(4'b1010);
        wait_done();

        // T4: ghost 2 sees no legal move
        resp[0] = 4'b1000; resp[1] = 4'b0001; resp[2] = 4'b0000; resp[3] = 4'b0010;
        start_round(4'b1111);
        wait_done();
        check("t4_ghost2_kept", 64'(ghost_dir[11:8]), 64'(4'b0100));
        check("no_overrun_yet", 64'(overrun), 64'(0));

        // T5: second tick four cycles into the round
        rand_resp();
        start_round(4'b1111);
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        wait_done();
        repeat (NG * (L + 1) + 4) @(negedge clk);
        check("t5_overrun_set", 64'(overrun), 64'(1));
        check("t5_idle_after", 64'(busy), 64'(0));

        // Tick during DONE of an empty round is ignored
        start_round('0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        check("done_tick_no_restart", 64'(busy), 64'(0));

        // Random rounds, some with ignored ticks while busy
        for (int n = 0; n < 24; n++) begin
            rand_resp();
            en = NG'($urandom);
            start_round(en);
            if (en != '0 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                frame_tick = 1'b1;
                @(negedge clk);
                frame_tick = 1'b0;
            end
            wait_done();
        end
        check("overrun_sticky", 64'(overrun), 64'(1));

        // T6: reset during ghost 1's wait
        rand_resp();
        resp[0] = 4'b0010;
        pre_dir0 = mdir[0];
        start_round(4'b1111);
        repeat (3) @(negedge clk);
        check("t6_ghost0_captured", 64'(ghost_dir[3:0]), 64'(4'b0010));
        check("t6_ghost0_changed", 64'(ghost_dir[3:0] != pre_dir0 || pre_dir0 == 4'b0010), 64'(1));
        #1;
        rst_n = 1'b0;
        serve_q.delete();
        round_q.delete();
        for (int i = 0; i < NG; i++) mdir[i] = 4'b1000;
        #2;
        check_reset_state("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_target = done_seen;
        repeat (NG * (L + 1) + 4) @(negedge clk);
        check("t6_no_round_done", 64'(done_seen), 64'(done_target));
        check("t6_dirs_after", 64'(ghost_dir), 64'({NG{4'b1000}}));

        // Recovery round after reset
        rand_resp();
        start_round(4'b0111);
        wait_done();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(serve_q.size() + round_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
